imem_boot_loader: RTL and testbench

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader.sv | 121 ++++++++++++
 tb/tb_imem_boot_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a boot image into instruction memory, then runs the core until halt or timeout.
// Optional BOOT_CHECKSUM_EN adds in_sum and rejects images whose word sum does not match.
module imem_boot_loader #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 256,
  parameter int RUN_CYCLES = 100,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   core_pc,
  output logic              core_rst,
  output logic              run_done,
  output logic              halted,
  output logic              load_err
`ifdef BOOT_CHECKSUM_EN
  ,
  input  logic [XLEN-1:0]   in_sum
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [RUN_W-1:0] RUN_LAST_C = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, RUN, DONE, ERR} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  wcnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [XLEN-1:0]   prev_pc;
  logic              pc_seen;
  logic              xfer, overflow, halt_hit, time_up, sum_ok;

`ifdef BOOT_CHECKSUM_EN
  logic [XLEN-1:0]   sum;
  assign sum_ok = ((sum + in_data) == in_sum);
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    core_rst = 1'b1;
    run_done = 1'b0;
    load_err = 1'b0;
    xfer     = 1'b0;
    overflow = 1'b0;
    halt_hit = 1'b0;
    time_up  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = !rst;
        xfer     = in_valid && !rst;
        overflow = (wcnt == DEPTH_C);
        if (xfer) begin
          if (overflow)     state_nx = ERR;
          else if (in_last) state_nx = sum_ok ? RUN : ERR;
        end
      end
      RUN: begin
        core_rst = rst;
        // A pc that repeats across consecutive run cycles is the jal x0,0 idle loop.
        halt_hit = pc_seen && (core_pc == prev_pc);
        time_up  = (run_cnt == RUN_LAST_C);
        if (halt_hit || time_up) state_nx = DONE;
      end
      DONE: run_done = 1'b1;
      ERR:  load_err = 1'b1;
      default: state_nx = LOAD;
    endcase
  end

  // The final word's write pulse lands in the first RUN cycle; no new writes are issued there.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      run_cnt   <= '0;
      prev_pc   <= '0;
      pc_seen   <= 1'b0;
      halted    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_we <= xfer && !overflow;
      if (xfer && !overflow) begin
        mem_addr  <= wcnt[ADDR_W-1:0];
        mem_wdata <= in_data;
        wcnt      <= wcnt + CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
        sum       <= sum + in_data;
`endif
      end
      if (state == RUN) begin
        run_cnt <= run_cnt + RUN_W'(1);
        prev_pc <= core_pc;
        pc_seen <= 1'b1;
        if (halt_hit) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed bench for imem_boot_loader (DEPTH=4, RUN_CYCLES=100).
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] core_pc = '0;
  logic        core_rst, run_done, halted, load_err;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] in_sum = '0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [1:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] prog[4];

  imem_boot_loader #(.XLEN(32), .DEPTH(4), .RUN_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_pc(core_pc), .core_rst(core_rst), .run_done(run_done),
    .halted(halted), .load_err(load_err)
`ifdef BOOT_CHECKSUM_EN
    , .in_sum(in_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int lowcnt;
    prog[0] = 32'h00500093;
    prog[1] = 32'h00100113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h0000006F;

    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_core_rst", core_rst, 1);
    rst = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1);
    check("idle_core_rst", core_rst, 1);
    check("idle_run_done", run_done, 0);
    check("idle_halted", halted, 0);
    check("idle_load_err", load_err, 0);
    check("idle_mem_we", mem_we, 0);

    // Four-word program ending in a self-loop at 0xC
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = prog[i]; in_last = (i == 3);
      step();
      check("a_we", mem_we, 1);
      check("a_addr", mem_addr, i);
      check("a_wdata", mem_wdata, prog[i]);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("a_run_core_rst", core_rst, 0);
    check("a_run_in_ready", in_ready, 0);
    core_pc = 32'h0;  step();
    core_pc = 32'h4;  step();
    core_pc = 32'h8;  step();
    core_pc = 32'hC;  step();
    check("a_not_done_yet", run_done, 0);
    core_pc = 32'hC;  step();
    check("a_run_done", run_done, 1);
    check("a_halted", halted, 1);
    check("a_done_core_rst", core_rst, 1);
    check("a_done_in_ready", in_ready, 0);
    check("a_nwrites", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        check("a_log_addr", log_addr[i], i);
        check("a_log_data", log_data[i], prog[i]);
      end
    end

    // Single word, pc keeps advancing: forced stop after exactly RUN_CYCLES cycles
    do_reset();
    in_valid = 1'b1; in_data = 32'h13; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (core_rst !== 1'b0) break;
      lowcnt++;
      core_pc = 32'(4 * k);
      step();
    end
    check("b_low_cycles", lowcnt, 100);
    check("b_run_done", run_done, 1);
    check("b_halted", halted, 0);
    check("b_load_err", load_err, 0);

    // Image larger than memory
    do_reset();
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i); in_last = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("c_load_err", load_err, 1);
    check("c_core_rst", core_rst, 1);
    check("c_in_ready", in_ready, 0);
    step();
    check("c_mem_we", mem_we, 0);
    check("c_nwrites", log_addr.size(), 4);
    if (log_addr.size() == 4) check("c_last_data", log_data[3], 32'h103);
    step();
    check("c_err_sticky", load_err, 1);
    check("c_err_core_rst", core_rst, 1);

    // Reset during RUN cycle 10, then gapped reload and DONE with in_valid held
    do_reset();
    check("d_err_cleared", load_err, 0);
    in_valid = 1'b1; in_data = 32'h13; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      core_pc = 32'(4 * k);
      step();
    end
    check("d_running", core_rst, 0);
    core_pc = 32'd40;
    rst = 1'b1;
    #1;
    check("d_rst_core_rst", core_rst, 1);
    check("d_rst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("d_post_core_rst", core_rst, 1);
    check("d_post_in_ready", in_ready, 1);
    check("d_post_run_done", run_done, 0);
    check("d_post_halted", halted, 0);
    log_addr.delete(); log_data.delete();
    in_valid = 1'b1; in_data = 32'hAAAA0001; in_last = 1'b0; step();
    in_valid = 1'b0; in_data = 32'hDEADBEEF; in_last = 1'b1; step();
    in_valid = 1'b1; in_data = 32'hBBBB0002; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    check("d_reload_run", core_rst, 0);
    core_pc = 32'h0; step();
    core_pc = 32'h0; step();
    check("d_done", run_done, 1);
    check("d_halted", halted, 1);
    in_valid = 1'b1; in_data = 32'h0BAD0BAD;
    for (int k = 0; k < 4; k++) begin
      check("d_done_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    step();
    check("d_done_sticky", run_done, 1);
    check("d_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("d_addr0", log_addr[0], 0);
      check("d_data0", log_data[0], 32'hAAAA0001);
      check("d_addr1", log_addr[1], 1);
      check("d_data1", log_data[1], 32'hBBBB0002);
    end

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    in_sum = 32'd6;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_last = (i == 3); step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("e_sum_ok_run", core_rst, 0);
    check("e_sum_ok_err", load_err, 0);
    do_reset();
    in_sum = 32'd7;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_last = (i == 3); step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("e_sum_bad_err", load_err, 1);
    lowcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (core_rst !== 1'b1) lowcnt++;
      step();
    end
    check("e_sum_bad_core_rst", lowcnt, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
